// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        BFLUSH = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned CNT_W   = 3;

endpackage

// File: rtl/hazard_if.sv
// Decode/execute/memory hazard signals between the pipeline and hazard_ctrl.
// HAZARD_PERF_CNT_EN adds the stall/flush performance counters.
interface hazard_if;

    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic        D_Branch;
    logic        X_MemRead;
    logic        X_RegWrite;
    logic [4:0]  X_writeReg;
    logic        M_MemRead;
    logic [4:0]  M_writeReg;
    logic        branchTaken;
    logic        pcWrite;
    logic        IFIDwrite;
    logic        hazardIFIDflush;
    logic        hazardIDEXflush;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    modport master (
        output D_rs, D_rt, D_Branch, X_MemRead, X_RegWrite, X_writeReg,
               M_MemRead, M_writeReg, branchTaken,
        input  pcWrite, IFIDwrite, hazardIFIDflush, hazardIDEXflush,
               stallCount, flushCount
    );
    modport slave (
        input  D_rs, D_rt, D_Branch, X_MemRead, X_RegWrite, X_writeReg,
               M_MemRead, M_writeReg, branchTaken,
        output pcWrite, IFIDwrite, hazardIFIDflush, hazardIDEXflush,
               stallCount, flushCount
    );
`else
    modport master (
        output D_rs, D_rt, D_Branch, X_MemRead, X_RegWrite, X_writeReg,
               M_MemRead, M_writeReg, branchTaken,
        input  pcWrite, IFIDwrite, hazardIFIDflush, hazardIDEXflush
    );
    modport slave (
        input  D_rs, D_rt, D_Branch, X_MemRead, X_RegWrite, X_writeReg,
               M_MemRead, M_writeReg, branchTaken,
        output pcWrite, IFIDwrite, hazardIFIDflush, hazardIDEXflush
    );
`endif

endinterface

// File: rtl/hazard_match.sv
// True when a non-zero destination register feeds either ID source; purely combinational.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [4:0] r_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    output logic       match_o
);

    assign match_o = (r_i != REG_ZERO) && ((r_i == rs_i) || (r_i == rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use/branch-dependency stall and taken-branch flush control; zero-cycle outputs, state on negedge clk.
// No backpressure; HAZARD_PERF_CNT_EN adds saturating stallCount/flushCount.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned BRANCH_FLUSH_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    hazard_if.slave hz
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BRANCH_FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_match, m_match;
    logic             load_use, br_dep;
    logic             pc_wr, ifid_wr, ifid_flush, idex_flush;

    hazard_match u_x_match (
        .r_i     (hz.X_writeReg),
        .rs_i    (hz.D_rs),
        .rt_i    (hz.D_rt),
        .match_o (x_match)
    );

    hazard_match u_m_match (
        .r_i     (hz.M_writeReg),
        .rs_i    (hz.D_rs),
        .rt_i    (hz.D_rt),
        .match_o (m_match)
    );

    assign load_use = hz.X_MemRead && x_match;
    assign br_dep   = hz.D_Branch && ((hz.X_RegWrite && x_match) || (hz.M_MemRead && m_match));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_wr      = 1'b1;
        ifid_wr    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            // Hold the pipeline frozen and bubbled while in reset.
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
        end else if (hz.branchTaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                state_d = BFLUSH;
                cnt_d   = RELOAD;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (state_q == BFLUSH) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = RUN;
            end
        end else if (load_use || br_dep) begin
            pc_wr      = 1'b0;
            ifid_wr    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.pcWrite         = pc_wr;
    assign hz.IFIDwrite       = ifid_wr;
    assign hz.hazardIFIDflush = ifid_flush;
    assign hz.hazardIDEXflush = idex_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic        stall;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    assign stall = !hz.branchTaken && (state_q == RUN) && (load_use || br_dep);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (ifid_flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hz.stallCount = stall_cnt_q;
    assign hz.flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl with a queue-based scoreboard and a flush-countdown reference model.
module tb_hazard_ctrl;

    localparam int BFC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_if hz ();

    hazard_ctrl #(.BRANCH_FLUSH_CYCLES(BFC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       xmr;
        logic       xrw;
        logic [4:0] xwr;
        logic       mmr;
        logic [4:0] mwr;
        logic       bt;
    } stim_t;

    typedef struct {
        logic [3:0]  outs;
        logic [15:0] sc;
        logic [15:0] fc;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   flush_left = 0;
    int   m_sc = 0;
    int   m_fc = 0;

    function automatic stim_t idle();
        stim_t s;
        s.r = 1'b1; s.rs = '0; s.rt = '0; s.br = 1'b0;
        s.xmr = 1'b0; s.xrw = 1'b0; s.xwr = '0;
        s.mmr = 1'b0; s.mwr = '0; s.bt = 1'b0;
        return s;
    endfunction

    function automatic bit hit(logic [4:0] r, stim_t s);
        return (r != 0) && ((r == s.rs) || (r == s.rt));
    endfunction

    // Expected outputs are {pcWrite, IFIDwrite, hazardIFIDflush, hazardIDEXflush}.
    task automatic apply(input stim_t s, input string tag);
        exp_t e;
        bit   hazard;
        @(posedge clk);
        #1;
        rst = s.r;
        hz.D_rs = s.rs; hz.D_rt = s.rt; hz.D_Branch = s.br;
        hz.X_MemRead = s.xmr; hz.X_RegWrite = s.xrw; hz.X_writeReg = s.xwr;
        hz.M_MemRead = s.mmr; hz.M_writeReg = s.mwr; hz.branchTaken = s.bt;
        hazard = (s.xmr && hit(s.xwr, s)) ||
                 (s.br && ((s.xrw && hit(s.xwr, s)) || (s.mmr && hit(s.mwr, s))));
        e.tag = tag;
        if (!s.r) begin
            e.outs = 4'b0011;
            flush_left = 0;
            m_sc = 0;
            m_fc = 0;
            e.sc = '0;
            e.fc = '0;
        end else begin
            e.sc = 16'(m_sc);
            e.fc = 16'(m_fc);
            if (s.bt) begin
                e.outs = 4'b1111;
                flush_left = BFC - 1;
            end else if (flush_left > 0) begin
                e.outs = 4'b1111;
                flush_left--;
            end else if (hazard) begin
                e.outs = 4'b0001;
                if (m_sc < 65535) m_sc++;
            end else begin
                e.outs = 4'b1100;
            end
            if (e.outs[1] && m_fc < 65535) m_fc++;
        end
        sb_q.push_back(e);
    endtask

    exp_t       mon_e;
    logic [3:0] mon_got;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (sb_q.size() > 0) begin
                mon_e   = sb_q.pop_front();
                mon_got = {hz.pcWrite, hz.IFIDwrite, hz.hazardIFIDflush, hz.hazardIDEXflush};
                checks++;
                if (mon_got !== mon_e.outs) begin
                    errors++;
                    $display("FAIL %s outs got %b want %b at %0t", mon_e.tag, mon_got, mon_e.outs, $time);
                end
`ifdef HAZARD_PERF_CNT_EN
                checks++;
                if (hz.stallCount !== mon_e.sc || hz.flushCount !== mon_e.fc) begin
                    errors++;
                    $display("FAIL %s counters got %h/%h want %h/%h", mon_e.tag,
                             hz.stallCount, hz.flushCount, mon_e.sc, mon_e.fc);
                end
`endif
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        s = idle();
        s.r = 1'b0;
        s.xmr = 1'b1; s.xwr = 5'd5; s.rs = 5'd5; s.bt = 1'b1;
        apply(s, "reset_state");
        apply(s, "reset_hold");

        s = idle();
        s.xmr = 1'b1; s.xwr = 5'd5; s.rs = 5'd5;
        apply(s, "load_use");
        s.xmr = 1'b0;
        apply(s, "after_load_use");

        s = idle();
        s.xmr = 1'b1; s.xwr = 5'd0; s.rs = 5'd0;
        apply(s, "reg_zero");

        s = idle();
        s.xmr = 1'b1; s.xwr = 5'd7; s.rt = 5'd7;
        for (int i = 0; i < 4; i++) apply(s, "persist_stall");

        s = idle();
        s.br = 1'b1; s.xrw = 1'b1; s.xwr = 5'd9; s.rt = 5'd9;
        apply(s, "br_dep_x");
        s = idle();
        s.br = 1'b1; s.mmr = 1'b1; s.mwr = 5'd3; s.rs = 5'd3;
        apply(s, "br_dep_m");
        s.br = 1'b0;
        apply(s, "no_branch_m_load");

        s = idle();
        s.bt = 1'b1;
        apply(s, "bt_single");
        s.bt = 1'b0;
        for (int i = 0; i < 4; i++) apply(s, "bt_single_tail");

        s.bt = 1'b1;
        apply(s, "bt_first");
        s.bt = 1'b0;
        apply(s, "bt_flush2");
        s.bt = 1'b1;
        apply(s, "bt_reload");
        s.bt = 1'b0;
        for (int i = 0; i < 4; i++) apply(s, "bt_reload_tail");

        s = idle();
        s.bt = 1'b1; s.xmr = 1'b1; s.xwr = 5'd4; s.rs = 5'd4;
        apply(s, "bt_with_load_use");
        s.bt = 1'b0;
        apply(s, "flush_over_load_use");

        s = idle();
        s.bt = 1'b1;
        apply(s, "bt_pre_rst");
        s.bt = 1'b0; s.r = 1'b0;
        apply(s, "rst_mid_flush");
        s.r = 1'b1;
        apply(s, "after_rst");
        apply(s, "after_rst2");

        for (int i = 0; i < 3000; i++) begin
            s.r   = ($urandom_range(0, 49) != 0);
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.br  = 1'($urandom);
            s.xmr = 1'($urandom);
            s.xrw = 1'($urandom);
            s.xwr = 5'($urandom_range(0, 3));
            s.mmr = 1'($urandom);
            s.mwr = 5'($urandom_range(0, 3));
            s.bt  = ($urandom_range(0, 7) == 0);
            apply(s, "random");
        end

`ifdef HAZARD_PERF_CNT_EN
        s = idle();
        s.xmr = 1'b1; s.xwr = 5'd2; s.rs = 5'd2;
        for (int i = 0; i < 70000; i++) apply(s, "stall_saturate");
        s.xmr = 1'b0;
        apply(s, "stall_saturated");
`endif

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #5;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
